// File: rtl/pio_cmd_sequencer.sv
// pio_cmd_sequencer: turns toggle-based commands from an HPS-written PIO word
// into valid/ready transactions for the LBM core, waits for completion and
// reports ack toggle, busy, timeout error and a completion count on a status word.
module pio_cmd_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned CNT_W          = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] cmd_in,
  output logic        cmd_valid,
  output logic [2:0]  cmd_opcode,
  output logic [27:0] cmd_arg,
  input  logic        cmd_ready,
  input  logic        cmd_done,
  output logic [31:0] status_out
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_DONE = 2'd2
  } state_t;

  // A zero timeout disables the abort path entirely.
  localparam bit          TMO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

  state_t             state_q, state_d;
  logic               last_toggle_q, last_toggle_d;
  logic [2:0]         opcode_q, opcode_d;
  logic [27:0]        arg_q, arg_d;
  logic               cmd_valid_q, cmd_valid_d;
  logic [31:0]        timer_q, timer_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               error_q, error_d;
  logic               ack_q, ack_d;
  logic               busy_q, busy_d;

  logic               toggle_chg;
  logic               is_nop;
  logic               accept;
  logic               tmo_hit;

  assign toggle_chg = (cmd_in[31] != last_toggle_q);
  assign is_nop     = (cmd_in[30:28] == 3'd0);
  assign accept     = cmd_valid_q & cmd_ready;
  // >= rather than == so a handshake that wins on the expiry cycle still
  // times out on the following cycle if the core never completes.
  assign tmo_hit    = TMO_EN && (timer_q >= TMO_LAST);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state decode; completion events take priority over the timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (toggle_chg && !is_nop) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (accept)       state_d = S_WAIT_DONE;
        else if (tmo_hit) state_d = S_IDLE;
      end
      S_WAIT_DONE: begin
        if (cmd_done)     state_d = S_IDLE;
        else if (tmo_hit) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values for every registered output.
  always_comb begin
    last_toggle_d = last_toggle_q;
    opcode_d      = opcode_q;
    arg_d         = arg_q;
    cmd_valid_d   = cmd_valid_q;
    timer_d       = timer_q;
    count_d       = count_q;
    error_d       = error_q;
    ack_d         = ack_q;
    busy_d        = busy_q;
    case (state_q)
      S_IDLE: begin
        if (toggle_chg) begin
          last_toggle_d = cmd_in[31];
          opcode_d      = cmd_in[30:28];
          arg_d         = cmd_in[27:0];
          error_d       = 1'b0;
          timer_d       = '0;
          if (!is_nop) begin
            cmd_valid_d = 1'b1;
            busy_d      = 1'b1;
          end else begin
            ack_d       = cmd_in[31];
          end
        end
      end
      S_ISSUE: begin
        timer_d = timer_q + 32'd1;
        if (accept) begin
          cmd_valid_d = 1'b0;
        end else if (tmo_hit) begin
          cmd_valid_d = 1'b0;
          error_d     = 1'b1;
          ack_d       = last_toggle_q;
          busy_d      = 1'b0;
        end
      end
      S_WAIT_DONE: begin
        timer_d = timer_q + 32'd1;
        if (cmd_done) begin
          busy_d  = 1'b0;
          ack_d   = last_toggle_q;
          count_d = count_q + 1'b1;
        end else if (tmo_hit) begin
          error_d = 1'b1;
          ack_d   = last_toggle_q;
          busy_d  = 1'b0;
        end
      end
      default: begin
        cmd_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  // Datapath and handshake registers; async reset drops cmd_valid at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_toggle_q <= 1'b0;
      opcode_q      <= '0;
      arg_q         <= '0;
      cmd_valid_q   <= 1'b0;
      timer_q       <= '0;
      count_q       <= '0;
      error_q       <= 1'b0;
      ack_q         <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      last_toggle_q <= last_toggle_d;
      opcode_q      <= opcode_d;
      arg_q         <= arg_d;
      cmd_valid_q   <= cmd_valid_d;
      timer_q       <= timer_d;
      count_q       <= count_d;
      error_q       <= error_d;
      ack_q         <= ack_d;
      busy_q        <= busy_d;
    end
  end

  assign cmd_valid  = cmd_valid_q;
  assign cmd_opcode = opcode_q;
  assign cmd_arg    = arg_q;
  assign status_out = {ack_q, busy_q, error_q, {(29 - CNT_W){1'b0}}, count_q};

endmodule

// File: tb/tb_pio_cmd_sequencer.sv
// Bench for pio_cmd_sequencer: scoreboard of expected commands popped on each
// cmd_valid/cmd_ready handshake, plus direct status word checks.
module tb_pio_cmd_sequencer;

  localparam int TMO = 20;
  localparam int CW  = 8;

  logic        clk       = 1'b0;
  logic        reset_n   = 1'b0;
  logic [31:0] cmd_in    = '0;
  logic        cmd_ready = 1'b0;
  logic        cmd_done  = 1'b0;
  logic        cmd_valid;
  logic [2:0]  cmd_opcode;
  logic [27:0] cmd_arg;
  logic [31:0] status_out;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [30:0] sb[$];
  logic        tgl      = 1'b0;
  logic        old_tgl;
  int          exp_cnt  = 0;

  always #5 clk = ~clk;

  pio_cmd_sequencer #(
    .TIMEOUT_CYCLES(TMO),
    .CNT_W         (CW)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cmd_in    (cmd_in),
    .cmd_valid (cmd_valid),
    .cmd_opcode(cmd_opcode),
    .cmd_arg   (cmd_arg),
    .cmd_ready (cmd_ready),
    .cmd_done  (cmd_done),
    .status_out(status_out)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_status(input logic ack, input logic busy,
                                             input logic err, input int cnt);
    return {ack, busy, err, 21'd0, 8'(cnt)};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [2:0] op, input logic [27:0] arg, input bit expect_hs);
    tgl    = ~tgl;
    cmd_in = {tgl, op, arg};
    if (expect_hs) sb.push_back({op, arg});
  endtask

  task automatic done_pulse;
    cmd_done = 1'b1;
    tick;
    cmd_done = 1'b0;
  endtask

  // Scoreboard: every accepted command must match the oldest expected one.
  always @(negedge clk) begin
    if (reset_n && cmd_valid && cmd_ready) begin
      check_eq("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) check_eq("sb_cmd", {cmd_opcode, cmd_arg}, sb.pop_front());
    end
  end

  initial begin
    #(200000 * 10);
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_status", status_out, 0);
    check_eq("rst_valid",  cmd_valid,  0);
    check_eq("rst_opcode", cmd_opcode, 0);
    check_eq("rst_arg",    cmd_arg,    0);
    tick;
    reset_n = 1'b1;
    tick;

    // Basic command with ready high
    cmd_ready = 1'b1;
    send_cmd(3'd3, 28'h123, 1'b1);
    tick;
    @(negedge clk);
    check_eq("A_valid",  cmd_valid,     1);
    check_eq("A_opcode", cmd_opcode,    3);
    check_eq("A_arg",    cmd_arg,       28'h123);
    check_eq("A_busy",   status_out[30], 1);
    tick;
    @(negedge clk);
    check_eq("A_valid_drop", cmd_valid, 0);
    done_pulse;
    exp_cnt = 1;
    @(negedge clk);
    check_eq("A_status", status_out, 32'h8000_0001);

    // Backpressure: ready low for 10 cycles, cmd_in noise must not leak
    tick;
    cmd_ready = 1'b0;
    send_cmd(3'd6, 28'hABCDEF, 1'b1);
    tick;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("B_valid",  cmd_valid, 1);
      check_eq("B_cmd",    {cmd_opcode, cmd_arg}, {3'd6, 28'hABCDEF});
      check_eq("B_busy",   status_out[30], 1);
      tick;
      cmd_in[30:0] = 31'($urandom);
    end
    cmd_ready = 1'b1;
    tick;
    @(negedge clk);
    check_eq("B_valid_drop", cmd_valid, 0);
    check_eq("B_busy_wait",  status_out[30], 1);
    done_pulse;
    exp_cnt = 2;
    @(negedge clk);
    check_eq("B_status", status_out, exp_status(tgl, 0, 0, exp_cnt));

    // Toggle while in WAIT_DONE is held until the first IDLE cycle
    tick;
    send_cmd(3'd2, 28'h55, 1'b1);
    tick;
    @(negedge clk);
    check_eq("C_valid1", cmd_valid, 1);
    tick;
    old_tgl = tgl;
    send_cmd(3'd5, 28'h77, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("C_no_valid", cmd_valid, 0);
      check_eq("C_busy",     status_out[30], 1);
      tick;
    end
    done_pulse;
    exp_cnt = 3;
    @(negedge clk);
    check_eq("C_status",     status_out, exp_status(old_tgl, 0, 0, exp_cnt));
    check_eq("C_valid_hold", cmd_valid, 0);
    tick;
    @(negedge clk);
    check_eq("C_reissue", cmd_valid,  1);
    check_eq("C_op5",     cmd_opcode, 5);
    tick;
    done_pulse;
    exp_cnt = 4;
    @(negedge clk);
    check_eq("C_status2", status_out, exp_status(tgl, 0, 0, exp_cnt));

    // Timeout: core never accepts
    tick;
    cmd_ready = 1'b0;
    send_cmd(3'd4, 28'h1, 1'b0);
    tick;
    @(negedge clk);
    check_eq("D_valid", cmd_valid, 1);
    repeat (19) tick;
    @(negedge clk);
    check_eq("D_pre_valid", cmd_valid,      1);
    check_eq("D_pre_err",   status_out[29], 0);
    tick;
    @(negedge clk);
    check_eq("D_valid_drop", cmd_valid,  0);
    check_eq("D_status",     status_out, exp_status(tgl, 0, 1, exp_cnt));

    // NOP flips ack next cycle and clears the sticky error
    tick;
    send_cmd(3'd0, 28'h9, 1'b0);
    @(negedge clk);
    check_eq("E_pre",    status_out, exp_status(~tgl, 0, 1, exp_cnt));
    tick;
    @(negedge clk);
    check_eq("E_status", status_out, exp_status(tgl, 0, 0, exp_cnt));
    check_eq("E_valid",  cmd_valid,  0);
    tick;
    @(negedge clk);
    check_eq("E_valid2", cmd_valid,  0);

    // Count wrap at 2^CNT_W
    tick;
    cmd_ready = 1'b1;
    for (int i = 0; i < 251; i++) begin
      send_cmd(3'd1, 28'(i), 1'b1);
      tick;
      tick;
      done_pulse;
      exp_cnt = (exp_cnt + 1) % 256;
      tick;
    end
    @(negedge clk);
    check_eq("F_cnt_ff", status_out, exp_status(tgl, 0, 0, exp_cnt));
    tick;
    send_cmd(3'd1, 28'hFFF, 1'b1);
    tick;
    tick;
    done_pulse;
    exp_cnt = (exp_cnt + 1) % 256;
    @(negedge clk);
    check_eq("F_wrap", status_out, exp_status(tgl, 0, 0, exp_cnt));

    // Asynchronous reset during ISSUE
    tick;
    cmd_ready = 1'b0;
    send_cmd(3'd7, 28'h3, 1'b0);
    tick;
    @(negedge clk);
    check_eq("G_valid", cmd_valid, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("G_valid_async", cmd_valid,  0);
    check_eq("G_status",      status_out, 0);
    cmd_in = '0;
    tgl    = 1'b0;
    tick;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("G_post_valid",  cmd_valid,  0);
      check_eq("G_post_status", status_out, 0);
      tick;
    end

    check_eq("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pio_cmd_sequencer.md
Name: pio_cmd_sequencer

Overview:
- Downstream consumer of the 32-bit HPS-written PIO output word (out_port of the direction/command PIO).
- Decodes a toggle-based command word and issues each command to the LBM compute core over a valid/ready handshake, then waits for a completion pulse.
- Produces a 32-bit status word for a companion input PIO so software can poll for completion, busy and timeout.
- The PIO word is in the same clk domain, so no synchronizer is needed.

Parameters:
- TIMEOUT_CYCLES, 1000000: maximum cycles spent in ISSUE+WAIT_DONE before abort; 0 disables the timeout.
- CNT_W, 16: width of the completion counter; must be ≤ 16.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- cmd_in  in  32  PIO word: [31] go toggle, [30:28] opcode, [27:0] argument.
- cmd_valid  out  1  command offered to the core.
- cmd_opcode  out  3  latched opcode, stable while cmd_valid=1.
- cmd_arg  out  28  latched argument, stable while cmd_valid=1.
- cmd_ready  in  1  core accepts the command when cmd_valid and cmd_ready are both 1 at a clock edge.
- cmd_done  in  1  one-cycle completion pulse from the core.
- status_out  out  32  [31] ack toggle, [30] busy, [29] timeout error, [28:CNT_W] zero, [CNT_W-1:0] completion count.

Behaviour:
- Reset values: all outputs 0, state IDLE, last_toggle 0, timer 0, count 0, error 0, cmd_opcode 0, cmd_arg 0.
- Register status_out and all handshake outputs; there is no combinational path from an input to an output.
- IDLE:
  - When cmd_in[31] != last_toggle at a clock edge, latch opcode, argument and toggle into last_toggle, and clear the error bit.
  - If opcode != 0: go to ISSUE. cmd_valid=1 and busy=1 are visible one cycle after the toggle change is sampled. Clear the timer.
  - If opcode == 0 (NOP): stay in IDLE. Set ack toggle = new toggle the next cycle. Do not raise cmd_valid, do not change count, busy stays 0.
- ISSUE:
  - Hold cmd_valid=1 with stable opcode and argument until cmd_valid & cmd_ready at an edge.
  - On that edge: cmd_valid=0 the next cycle, go to WAIT_DONE. The timer keeps counting without a reset.
  - cmd_done in ISSUE is ignored.
- WAIT_DONE:
  - On cmd_done=1: go to IDLE. Next cycle: busy=0, ack toggle = last_toggle, count +1.
  - The count wraps from all-ones to 0.
  - Extra cmd_done pulses in IDLE are ignored.
- Timer:
  - Increments each cycle in ISSUE and WAIT_DONE.
  - When it reaches TIMEOUT_CYCLES-1 without completion: cmd_valid=0, error=1, ack toggle = last_toggle, busy=0, return to IDLE. The count is unchanged.
  - cmd_done or handshake completion on the expiry cycle wins over the timeout.
- A toggle change while busy is not lost: it is re-evaluated on the first IDLE cycle because last_toggle still differs.
  - cmd_in changes while busy do not alter the latched cmd_opcode or cmd_arg.
- Reset mid-operation drops cmd_valid immediately (asynchronously) and discards the in-flight command. No ack is generated.
- The error bit is sticky until the next accepted non-NOP or NOP command.

Test Plan:
- Reset, then cmd_in=0x80000000|(3<<28)|0x123, cmd_ready=1 -> cmd_valid=1 for 1 cycle with opcode 3, arg 0x123. Then cmd_done pulse -> status_out=0x80000001, busy 0.
- cmd_ready held 0 for 10 cycles after issue -> cmd_valid stays 1 with stable opcode/arg, busy=1; raise ready -> valid drops next cycle.
- Toggle bit cmd_in[31] again while in WAIT_DONE with opcode 5 -> no new cmd_valid until done; first IDLE cycle then issues opcode 5.
- TIMEOUT_CYCLES=20, core never asserts done -> 20 cycles after issue status_out[29]=1, busy 0, ack toggle matches, count unchanged.
- Opcode 0 (NOP) toggle -> no cmd_valid; ack toggle flips next cycle; count unchanged; a prior error bit clears.
- 65536 completed commands -> count wraps to 0x0000; assert reset_n low during ISSUE -> cmd_valid 0 immediately, status_out 0.
